fir_poly_seq: RTL

Sequencer for the polyphase decimating FIR datapath. It accepts input samples over a valid/ready handshake and registers each accepted sample for the banks. It drives the shared `tap_addr` / `dsp_acc` phase bus that steps every bank through its multiply-accumulate frame. It also flags the cycle on which the bank outputs hold a fresh decimated result. One instance sits between the ADC sample stream and the array of `bank` instances plus their DSP slices.

---
 rtl/fir_poly_pkg.sv | 28 ++
 rtl/fir_poly_seq_phase_counter.sv | 49 ++++
 rtl/fir_poly_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fir_poly_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_poly_pkg
//  Description : Shared definitions for the polyphase decimating FIR:
//                default geometry, the capture-phase function used by both
//                the sequencer and the banks, and the sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_poly_pkg;

    localparam int M_DEFAULT           = 20;
    localparam int BANK_LEN_DEFAULT    = 6;
    localparam int DSP_LAT_DEFAULT     = 2;
    localparam int INPUT_WIDTH_DEFAULT = 12;

    // Phase on which the banks latch dsp_p: the last product enters the DSP
    // at phase BANK_LEN-1 and emerges DSP_LAT cycles later, one phase after.
    function automatic int capture_addr(input int bank_len, input int dsp_lat);
        return bank_len + dsp_lat;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/fir_poly_seq_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fir_poly_seq_phase_counter
//  Description : Mod-M phase counter for the FIR sequencer. Resets to the
//                idle value M-1, loads 0 at a frame start, increments while
//                a frame runs and otherwise holds.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                load_i          - force phase to 0 next cycle
//                inc_i           - advance phase by one (caller keeps < M-1)
//                phase_o         - registered phase
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_poly_seq_phase_counter #(
    parameter int M      = 20,
    parameter int M_LOG2 = $clog2(M)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    output logic [M_LOG2-1:0] phase_o
);

    localparam logic [M_LOG2-1:0] IDLE_PHASE = M_LOG2'(M - 1);

    logic [M_LOG2-1:0] phase_q;
    logic [M_LOG2-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (load_i) begin
            phase_d = '0;
        end else if (inc_i) begin
            phase_d = phase_q + M_LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= IDLE_PHASE;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule
`default_nettype wire

// File: rtl/fir_poly_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fir_poly_seq
//  Description : Sequencer for the polyphase decimating FIR. Accepts samples
//                on a valid/ready handshake, broadcasts the registered sample
//                to the banks, drives the tap_addr/dsp_acc phase bus and
//                pulses dout_valid when the banks hold a fresh result.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                en                       - run enable (frame boundaries only)
//                din, din_valid, din_ready - sample input handshake
//                dout_din                 - registered accepted sample
//                tap_addr, dsp_acc        - phase bus to the banks / DSPs
//                dout_valid               - one-cycle fresh-result pulse
//                overrun, overrun_clr     - sticky drop flag and its clear
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_poly_seq
    import fir_poly_pkg::*;
#(
    parameter  int M            = M_DEFAULT,
    parameter  int BANK_LEN     = BANK_LEN_DEFAULT,
    parameter  int DSP_LAT      = DSP_LAT_DEFAULT,
    parameter  int INPUT_WIDTH  = INPUT_WIDTH_DEFAULT,
    localparam int M_LOG2       = $clog2(M),
    localparam int CAPTURE_ADDR = capture_addr(BANK_LEN, DSP_LAT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic signed [INPUT_WIDTH-1:0] din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic signed [INPUT_WIDTH-1:0] dout_din,
    output logic        [M_LOG2-1:0]      tap_addr,
    output logic                          dsp_acc,
    output logic                          dout_valid,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    // The capture phase must fall inside the frame, before the last phase,
    // otherwise the result would be overwritten by the next frame's shift.
    generate
        if (CAPTURE_ADDR >= M - 1) begin : g_bad_capture_addr
            $fatal(1, "fir_poly_seq: CAPTURE_ADDR (%0d) must be < M-1 (%0d)",
                   CAPTURE_ADDR, M - 1);
        end
    endgenerate

    localparam logic [M_LOG2-1:0] LAST_PHASE    = M_LOG2'(M - 1);
    localparam logic [M_LOG2-1:0] CAPTURE_PHASE = M_LOG2'(CAPTURE_ADDR);

    seq_state_e                    state_q;
    logic                          dsp_acc_q;
    logic                          dout_valid_q;
    logic                          overrun_q;
    logic signed [INPUT_WIDTH-1:0] dout_din_q;

    logic w_at_last;
    logic w_accept;
    logic w_inc;
    logic w_overrun_set;

    assign w_at_last = (tap_addr == LAST_PHASE);

    // Idle always parks at the last phase, so both cases open the same window.
    assign din_ready = en && ((state_q == ST_IDLE) || w_at_last);
    assign w_accept  = din_valid && din_ready;

    // Never wraps on its own: the only route from M-1 back to 0 is a load.
    assign w_inc = (state_q == ST_RUN) && !w_at_last;

    // A sample offered while disabled and idle is simply not for us.
    assign w_overrun_set = din_valid && !din_ready &&
                           !((state_q == ST_IDLE) && !en);

    fir_poly_seq_phase_counter #(
        .M      (M),
        .M_LOG2 (M_LOG2)
    ) u_phase_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_accept),
        .inc_i   (w_inc),
        .phase_o (tap_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dsp_acc_q    <= 1'b1;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            dout_din_q   <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                if (w_accept) begin
                    state_q <= ST_RUN;
                end
            end else begin
                if (w_at_last && !w_accept) begin
                    state_q <= ST_IDLE;
                end
            end

            // Next phase is 0 exactly when a sample is accepted this cycle.
            dsp_acc_q    <= !w_accept;
            dout_valid_q <= (state_q == ST_RUN) && (tap_addr == CAPTURE_PHASE);

            if (w_accept) begin
                dout_din_q <= din;
            end

            if (w_overrun_set) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign dsp_acc    = dsp_acc_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign dout_din   = dout_din_q;

endmodule
`default_nettype wire
